load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the MIPS data-memory interface. Accepts one load/store request at a time from the MEM stage.
//  Drives the word-only data memory (combinational read, posedge write) and returns load data or completion.
//  Adds byte/halfword access with sign/zero extension, read-modify-write for sub-word stores, and address checks.
// PARAMETERS
//  DATA_WIDTH    32             data/address width
//  BASE_ADDR     32'h10010000   first byte address of data memory
//  MEMORY_DEPTH  1024           memory size in words; valid bytes are BASE_ADDR .. BASE_ADDR+4*MEMORY_DEPTH-1
// PORTS
//  clk              in   1   clock, all state on posedge
//  reset            in   1   asynchronous, active-low reset
//  req_valid_i      in   1   request present
//  req_ready_o      out  1   unit idle; request accepted on clk edge when valid&ready
//  req_is_store_i   in   1   1=store, 0=load
//  req_size_i       in   2   00 byte, 01 half, 10 word, 11 reserved (treated as error)
//  req_unsigned_i   in   1   load zero-extends (lbu/lhu) when 1, sign-extends when 0
//  req_addr_i       in   32  byte address
//  req_wdata_i      in   32  store data, right-aligned
//  resp_valid_o     out  1   one-cycle completion pulse
//  resp_rdata_o     out  32  extended load data; 0 for stores and errors
//  resp_err_o       out  1   valid with resp_valid_o: misaligned, out of range, or reserved size
//  mem_address_o    out  32  word-aligned byte address {addr[31:2],2'b00} to memory
//  mem_write_data_o out  32  full word to write
//  mem_write_o      out  1   memory write enable
//  mem_read_o       out  1   memory read enable (memory returns 0 when low)
//  mem_data_i       in   32  memory read word, valid in same cycle as mem_read_o
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1; resp_valid_o, resp_err_o, mem_write_o, mem_read_o=0; resp_rdata_o, mem_* buses=0.
//  States: IDLE, RD, RMW_RD, WR, RESP. req_ready_o=1 only in IDLE; mem_read_o/mem_write_o decoded from state only.
//  IDLE accept: latch addr/size/unsigned/wdata. Then:
//    - error (addr[0]&half, addr[1:0]!=0&word, size=11, addr out of range) -> RESP with err=1, no memory access
//    - load -> RD; word store -> WR; byte/half store -> RMW_RD
//  RD: mem_read_o=1; extract lane from mem_data_i, extend, register into resp_rdata -> RESP
//  RMW_RD: mem_read_o=1; register mem_data_i merged with store bytes -> WR
//  WR: mem_write_o=1, mem_write_data_o=merged (or full wdata for word) -> RESP
//  RESP: resp_valid_o=1 for exactly one cycle -> IDLE; next request accepted on following edge.
//  Latency accept-edge to resp_valid_o high: load 2 cycles, word store 2, sub-word store 3, error 1.
//  Lanes little-endian: byte n = bits 8n+7:8n; half at addr[1]=1 is bits 31:16.
//  Range check uses (addr - BASE_ADDR) unsigned compared to 4*MEMORY_DEPTH; wrap below BASE is out of range.
//  mem_address_o holds latched aligned address in RD/RMW_RD/WR, else 0.
//  Reset mid-operation: immediate return to IDLE; a write in progress is dropped (mem_write_o falls before edge).
//  req_valid_i while busy is ignored (not latched); requester must hold it until ready.
// STRUCTURE
//  Package mips_lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, default BASE_ADDR.
//  Sub-module lsu_byte_lane (combinational): load extract+extend and store merge from addr[1:0], size, unsigned.
//  Top holds FSM, request latches, range/alignment check, response register.
// TESTING
//  Reset mid-WR of sw -> mem_write_o drops at once; memory word unchanged; req_ready_o=1 after release.
//  sw 0xDEADBEEF @0x10010004, then lw @0x10010004 -> resp_rdata_o=0xDEADBEEF, err=0, 2-cycle latency each.
//  sb 0x80 @0x10010007 over 0x11223344 -> memory 0x80223344; lb -> 0xFFFFFF80; lbu -> 0x00000080.
//  sh 0xABCD @0x10010002 over 0x11223344 -> 0xABCD3344; lh -> 0xFFFFABCD; resp 3 cycles after accept.
//  lw @0x10010002, lh @0x10010001, lw @0x1000FFFC, lw @0x10011000 -> resp_err_o=1, rdata=0, no mem_read_o/mem_write_o.
//  Back-to-back requests held valid -> ready low while busy, second accepted the cycle after RESP, no lost request.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes, FSM state
// codes, default memory window and the alignment rule.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [31:0] DEFAULT_BASE_ADDR    = 32'h1001_0000;
  localparam int          DEFAULT_MEMORY_DEPTH = 1024;

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: extracts and extends a byte/half/word from a
// memory word for loads, and merges right-aligned store data into a word.
module lsu_byte_lane
  import mips_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            addr_lo_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] mem_word_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic [DATA_WIDTH-1:0] merged_word_o
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;

  // Byte n of the word lives at bits 8n+7:8n, so the lane offset is addr*8.
  assign shamt = {addr_lo_i, 3'b000};

  // Load extraction/extension and store merge share the same lane mask.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    shifted     = mem_word_i >> shamt;
    load_data_o = mem_word_i;
    lane_mask   = '1;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = unsigned_i ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                 : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
        lane_mask   = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << shamt;
      end
      SZ_HALF: begin
        load_data_o = unsigned_i ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                 : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        lane_mask   = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
      end
      default: ;
    endcase
    lane_data     = (store_data_i << shamt) & lane_mask;
    merged_word_o = (mem_word_i & ~lane_mask) | lane_data;
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS data-memory initiator: accepts one load/store at a time, checks
// alignment and range, performs read-modify-write for sub-word stores and
// returns a single-cycle completion with extended load data.
module load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int                    MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_store_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam logic [DATA_WIDTH-1:0] RANGE_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;     // word to write: full store data or RMW merge
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] req_offset;
  logic [DATA_WIDTH-1:0] lane_load;
  logic [DATA_WIDTH-1:0] lane_merged;
  logic                  mem_phase;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the same compare.
  assign req_offset = req_addr_i - BASE_ADDR;
  assign req_err    = (req_size_i == SZ_RSVD)
                    || misaligned(req_size_i, req_addr_i[1:0])
                    || (req_offset >= RANGE_BYTES);

  assign req_ready_o = (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;

  lsu_byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .addr_lo_i     (addr_q[1:0]),
    .size_i        (size_q),
    .unsigned_i    (unsigned_q),
    .mem_word_i    (mem_data_i),
    .store_data_i  (wdata_q),
    .load_data_o   (lane_load),
    .merged_word_o (lane_merged)
  );

  // Next-state logic: request capture in IDLE, then the memory access sequence.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d     = req_addr_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          wdata_d    = req_wdata_i;
          word_d     = req_wdata_i;
          rdata_d    = '0;
          err_d      = req_err;
          if (req_err)                   state_d = ST_RESP;
          else if (!req_is_store_i)      state_d = ST_RD;
          else if (req_size_i == SZ_WORD) state_d = ST_WR;
          else                           state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        rdata_d = lane_load;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        word_d  = lane_merged;
        state_d = ST_WR;
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Memory strobes and buses decode from state alone; buses idle at zero.
  assign mem_phase        = (state_q == ST_RD) || (state_q == ST_RMW_RD) || (state_q == ST_WR);
  assign mem_read_o       = (state_q == ST_RD) || (state_q == ST_RMW_RD);
  assign mem_write_o      = (state_q == ST_WR);
  assign mem_address_o    = mem_phase ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_write_data_o = mem_write_o ? word_q : '0;

  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o   = resp_valid_o && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference model plus a
// word-wide data memory attached to the DUT, compared every cycle.
module tb_load_store_unit;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_is_store_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_write_data_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_data_i;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_is_store_i   (req_is_store_i),
    .req_size_i       (req_size_i),
    .req_unsigned_i   (req_unsigned_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .resp_valid_o     (resp_valid_o),
    .resp_rdata_o     (resp_rdata_o),
    .resp_err_o       (resp_err_o),
    .mem_address_o    (mem_address_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_write_o      (mem_write_o),
    .mem_read_o       (mem_read_o),
    .mem_data_i       (mem_data_i)
  );

  // Word-only data memory: combinational read, posedge write.
  logic [31:0] mem_words [DEPTH];
  logic [31:0] mem_offset;
  logic [9:0]  mem_idx;
  assign mem_offset = mem_address_o - BASE;
  assign mem_idx    = mem_offset[11:2];
  assign mem_data_i = mem_read_o ? mem_words[mem_idx] : 32'h0;
  always @(posedge clk) if (mem_write_o) mem_words[mem_idx] <= mem_write_data_o;

  // Reference model: flat byte image of the same memory.
  logic [7:0] model_bytes [4*DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] rdata;
    int          remaining;
  } exp_t;

  exp_t        pend[$];
  exp_t        cur;
  logic        checking = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one request: error rule, byte writes, extended load, latency.
  function automatic void model_apply(input logic st, input logic [1:0] sz, input logic uns,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      output logic err, output logic [31:0] rd, output int lat);
    logic [31:0] off;
    logic [31:0] val;
    int          nb;
    off = addr - BASE;
    nb  = 1 << sz;
    err = (sz == 2'b11) || ((addr & 32'(nb - 1)) != 0) || (off >= 32'(4 * DEPTH));
    rd  = 32'h0;
    if (err) begin
      lat = 1;
    end else if (st) begin
      for (int i = 0; i < nb; i++) model_bytes[int'(off) + i] = wd[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
    end else begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val = val | (32'(model_bytes[int'(off) + i]) << (8 * i));
      if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
      rd  = val;
      lat = 2;
    end
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int o;
    o = int'((addr - BASE) & 32'hFFFF_FFFC);
    return {model_bytes[o+3], model_bytes[o+2], model_bytes[o+1], model_bytes[o]};
  endfunction

  // Per-cycle compare of handshake, strobes, address and response against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("req_ready", {31'h0, req_ready_o}, {31'h0, pend.size() == 0});
      if (pend.size() != 0) begin
        cur = pend[0];
        cur.remaining = cur.remaining - 1;
        pend[0] = cur;
        if (cur.err) begin
          check("err_no_mem_read", {31'h0, mem_read_o}, 32'h0);
          check("err_no_mem_write", {31'h0, mem_write_o}, 32'h0);
        end else if (mem_read_o || mem_write_o) begin
          check("mem_address", mem_address_o, {cur.addr[31:2], 2'b00});
        end
        if (cur.remaining == 0) begin
          check("resp_valid", {31'h0, resp_valid_o}, 32'h1);
          check("resp_rdata", resp_rdata_o, cur.rdata);
          check("resp_err", {31'h0, resp_err_o}, {31'h0, cur.err});
          last_rdata = resp_rdata_o;
          last_err   = resp_err_o;
          void'(pend.pop_front());
        end else begin
          check("resp_valid_early", {31'h0, resp_valid_o}, 32'h0);
        end
      end else begin
        check("resp_valid_idle", {31'h0, resp_valid_o}, 32'h0);
        check("mem_strobes_idle", {30'h0, mem_read_o, mem_write_o}, 32'h0);
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, record the model's expectation.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   lat;
    int   waited = 0;
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_is_store_i = st;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wd;
    while (!req_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready_o) begin
      check("accept_timeout", 32'h0, 32'h1);
      req_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      e.addr = addr;
      model_apply(st, sz, uns, addr, wd, e.err, e.rdata, lat);
      e.remaining = lat;
      pend.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    req_valid_i = 1'b0;
    while (pend.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (pend.size() != 0) begin
      check("response_timeout", 32'(pend.size()), 32'h0);
      pend.delete();
    end
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    issue(st, sz, uns, addr, wd);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_words[i] = (i < 2) ? 32'h1122_3344 : {16'(i), ~16'(i)};
      for (int b = 0; b < 4; b++) model_bytes[4*i + b] = mem_words[i][8*b +: 8];
    end
    reset = 1'b0;
    req_valid_i = 1'b0; req_is_store_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, req_ready_o}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err_o}, 32'h0);
    check("rst_rdata", resp_rdata_o, 32'h0);
    check("rst_mem_strobes", {30'h0, mem_read_o, mem_write_o}, 32'h0);
    check("rst_mem_addr", mem_address_o, 32'h0);
    check("rst_mem_wdata", mem_write_data_o, 32'h0);
    reset = 1'b1;

    // Reset in the middle of a word store's write cycle.
    @(negedge clk);
    req_valid_i = 1'b1; req_is_store_i = 1'b1; req_size_i = 2'b10;
    req_addr_i = 32'h1001_0004; req_wdata_i = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    check("midwr_write_high", {31'h0, mem_write_o}, 32'h1);
    reset = 1'b0;
    #1;
    check("midwr_write_dropped", {31'h0, mem_write_o}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midwr_ready_after", {31'h0, req_ready_o}, 32'h1);
    check("midwr_word_kept", mem_words[1], 32'h1122_3344);
    checking = 1'b1;

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    check("sw_mem_word", mem_words[1], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
    check("lw_rdata", last_rdata, 32'hDEAD_BEEF);
    check("lw_err", {31'h0, last_err}, 32'h0);

    // Byte store with RMW, signed and unsigned byte loads.
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h1001_0007, 32'h0000_0080);
    check("sb_mem_word", mem_words[1], 32'h8022_3344);
    check("sb_model_word", mem_words[1], model_word(32'h1001_0004));
    do_req(1'b0, 2'b00, 1'b0, 32'h1001_0007, 32'h0);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h1001_0007, 32'h0);
    check("lbu_rdata", last_rdata, 32'h0000_0080);

    // Halfword store into upper lane, signed and unsigned half loads.
    do_req(1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_ABCD);
    check("sh_mem_word", mem_words[0], 32'hABCD_3344);
    do_req(1'b0, 2'b01, 1'b0, 32'h1001_0002, 32'h0);
    check("lh_rdata", last_rdata, 32'hFFFF_ABCD);
    do_req(1'b0, 2'b01, 1'b1, 32'h1001_0002, 32'h0);
    check("lhu_rdata", last_rdata, 32'h0000_ABCD);
    do_req(1'b0, 2'b00, 1'b0, 32'h1001_0001, 32'h0);
    check("lb_lane1", last_rdata, 32'h0000_0033);

    // Error cases: misaligned, below base, past end, reserved size.
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0);
    check("err_lw_misaligned", {31'h0, last_err}, 32'h1);
    do_req(1'b0, 2'b01, 1'b0, 32'h1001_0001, 32'h0);
    check("err_lh_misaligned", {31'h0, last_err}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0);
    check("err_below_base", {31'h0, last_err}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_1000, 32'h0);
    check("err_past_end", {31'h0, last_err}, 32'h1);
    check("err_past_end_rdata", last_rdata, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0);
    check("err_rsvd_size", {31'h0, last_err}, 32'h1);
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0006, 32'h5555_5555);
    check("err_store_no_write", mem_words[1], 32'h8022_3344);

    // Top-of-range boundary accesses are legal.
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0FFC, 32'h0);
    check("lw_last_word_err", {31'h0, last_err}, 32'h0);
    check("lw_last_word", last_rdata, {16'(DEPTH-1), ~16'(DEPTH-1)});
    do_req(1'b1, 2'b00, 1'b0, 32'h1001_0FFF, 32'h0000_005A);
    do_req(1'b0, 2'b00, 1'b1, 32'h1001_0FFF, 32'h0);
    check("lbu_last_byte", last_rdata, 32'h0000_005A);

    // Back-to-back requests with valid held high throughout.
    issue(1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'h0102_8384);
    issue(1'b0, 2'b01, 1'b0, 32'h1001_0010, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h1001_0011, 32'h0000_00F0);
    issue(1'b0, 2'b10, 1'b0, 32'h1001_0013, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0);
    wait_done();
    check("b2b_last_rdata", last_rdata, 32'h0102_F084);
    check("b2b_mem_word", mem_words[4], model_word(32'h1001_0010));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
